qpsk_deframer: RTL

- Sits directly downstream of the QPSK physical receiver.
- Consumes its 2-bit demodulated symbol stream; each detected frame is a burst of FRAME_SYMS symbols.
- Packs symbols into bytes, delimits frames, and buffers bytes in a FIFO.
- Output is a byte stream with valid/ready/last for the link/MAC layer.
- Provides admission control, gap resync and status counters.

---
 rtl/qpsk_deframer_pkg.sv | 17 +
 rtl/qpsk_deframer_sync_fifo.sv | 65 ++++++
 rtl/qpsk_deframer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/qpsk_deframer_pkg.sv
// Shared types and helpers for the QPSK receive path: frame geometry and the
// {last,data} entry carried by the byte FIFO.
package rx_pkg;

    localparam int FRAME_SYMS_DEFAULT = 63;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

    // Four 2-bit symbols per byte; a trailing partial byte still costs one entry.
    function automatic int bytes_per_frame(input int frame_syms);
        return (frame_syms + 3) / 4;
    endfunction

endpackage

// File: rtl/qpsk_deframer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head is visible combinationally
// and the last popped word is held while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] hold_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so pushing into a full FIFO is then legal.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? hold_reg : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            hold_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                hold_reg   <= mem[rd_ptr_reg];
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_deframer.sv
// Packs QPSK symbol bursts into bytes, delimits frames with last, admits whole
// frames only when the FIFO can hold them, and resyncs on mid-frame gaps.
module qpsk_deframer
    import rx_pkg::*;
#(
    parameter int FRAME_SYMS = FRAME_SYMS_DEFAULT,
    parameter int GAP_CYCLES = 64,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sym_valid,
    input  logic [1:0]  sym_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    input  logic        clear_stats,
    output logic        overflow,
    output logic        truncated,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_dropped
);

    localparam int BPF = bytes_per_frame(FRAME_SYMS);
    localparam int IW  = $clog2(FRAME_SYMS + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] IDLE_FRAME = 2'd0;
    localparam logic [1:0] ACTIVE     = 2'd1;
    localparam logic [1:0] DROPPING   = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [IW-1:0] sym_idx_reg, sym_idx_next;
    logic [GW-1:0] idle_reg, idle_next;
    logic [7:0]    acc_reg, acc_next;
    logic          wr_en_reg, wr_en_next;
    fifo_entry_t   wr_entry_reg, wr_entry_next;
    logic          wr_complete_reg, wr_complete_next;
    logic          overflow_reg, truncated_reg;
    logic [15:0]   frames_ok_reg, frames_dropped_reg;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fifo_entry_t   head;

    logic [CW:0]   committed;
    logic          admit;
    logic          admitted;
    logic          drop_now;
    logic          truncate_now;
    logic          gap_hit;
    logic          last_sym;
    logic [1:0]    slot;
    logic [7:0]    byte_w;

    // Occupancy includes the byte still sitting in the write stage, so an
    // admitted frame can never meet a full FIFO.
    assign committed = {1'b0, fifo_count} + {{CW{1'b0}}, wr_en_reg};
    assign admit     = (int'(committed) <= (FIFO_DEPTH - BPF));
    assign slot      = sym_idx_reg[1:0];
    assign last_sym  = (sym_idx_reg == IW'(FRAME_SYMS - 1));
    assign gap_hit   = !sym_valid && (idle_reg == GW'(GAP_CYCLES - 1)) && (sym_idx_reg != '0);

    always_comb begin
        state_next       = state_reg;
        sym_idx_next     = sym_idx_reg;
        acc_next         = acc_reg;
        wr_en_next       = 1'b0;
        wr_entry_next    = wr_entry_reg;
        wr_complete_next = 1'b0;
        drop_now         = 1'b0;
        truncate_now     = 1'b0;
        admitted         = (state_reg == ACTIVE);
        idle_next        = sym_valid ? '0 :
                           (idle_reg == GW'(GAP_CYCLES)) ? idle_reg : idle_reg + GW'(1);

        // First symbol of a byte lands in [7:6]; unfilled low bits stay zero.
        byte_w = (slot == 2'd0) ? 8'h00 : acc_reg;
        case (slot)
            2'd0:    byte_w[7:6] = sym_data;
            2'd1:    byte_w[5:4] = sym_data;
            2'd2:    byte_w[3:2] = sym_data;
            default: byte_w[1:0] = sym_data;
        endcase

        if (sym_valid) begin
            if (sym_idx_reg == '0) begin
                admitted = admit;
                drop_now = !admit;
            end
            acc_next = byte_w;
            if (admitted && ((slot == 2'd3) || last_sym)) begin
                wr_en_next         = 1'b1;
                wr_entry_next.last = last_sym;
                wr_entry_next.data = byte_w;
                wr_complete_next   = last_sym;
            end
            if (last_sym) begin
                sym_idx_next = '0;
                state_next   = IDLE_FRAME;
            end else begin
                sym_idx_next = sym_idx_reg + IW'(1);
                state_next   = admitted ? ACTIVE : DROPPING;
            end
        end else if (gap_hit) begin
            if (state_reg == ACTIVE) begin
                wr_en_next         = 1'b1;
                wr_entry_next.last = 1'b1;
                wr_entry_next.data = (slot == 2'd0) ? 8'h00 : acc_reg;
                truncate_now       = 1'b1;
            end
            sym_idx_next = '0;
            state_next   = IDLE_FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE_FRAME;
            sym_idx_reg     <= '0;
            idle_reg        <= '0;
            acc_reg         <= '0;
            wr_en_reg       <= 1'b0;
            wr_entry_reg    <= '0;
            wr_complete_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sym_idx_reg     <= sym_idx_next;
            idle_reg        <= idle_next;
            acc_reg         <= acc_next;
            wr_en_reg       <= wr_en_next;
            wr_entry_reg    <= wr_entry_next;
            wr_complete_reg <= wr_complete_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            overflow_reg       <= 1'b0;
            truncated_reg      <= 1'b0;
            frames_ok_reg      <= '0;
            frames_dropped_reg <= '0;
        end else begin
            if (wr_en_reg && wr_complete_reg) begin
                frames_ok_reg <= frames_ok_reg + 16'd1;
            end
            if (drop_now) begin
                frames_dropped_reg <= frames_dropped_reg + 16'd1;
                overflow_reg       <= 1'b1;
            end
            if (truncate_now) begin
                truncated_reg <= 1'b1;
            end
        end
    end

    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = wr_en_reg && (!fifo_full || fifo_pop);

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wr_entry_reg),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid      = !fifo_empty;
    assign out_data       = head.data;
    assign out_last       = head.last && !fifo_empty;
    assign overflow       = overflow_reg;
    assign truncated      = truncated_reg;
    assign frames_ok      = frames_ok_reg;
    assign frames_dropped = frames_dropped_reg;

endmodule
